// File: rtl/uart_tx_fifo.sv
// Buffered 8-bit UART transmitter.
// Bytes enter a small FIFO through a send_en/send_busy handshake and are
// serialised LSB first with optional parity and one or two stop bits.
// Frames are sent back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int CLK_FRE    = 50,
  parameter int UART_RATE  = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_en,
  input  logic [7:0] send_data,
  output logic       send_busy,
  output logic       tx_pin,
  output logic       tx_idle,
  output logic       overflow
);

  localparam int BAUD_DIV = CLK_FRE * 1_000_000 / UART_RATE;
  localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        data_q, data_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic wr_fire;
  logic pop;
  logic bit_end;
  logic parity_bit;

  assign send_busy  = (count_q == CNT_FULL);
  assign wr_fire    = send_en && !send_busy;
  assign bit_end    = (baud_cnt_q == BAUD_LAST);
  assign parity_bit = (PARITY == 1) ? ~^data_q : ^data_q;

  assign tx_pin   = tx_q;
  assign tx_idle  = (state_q == ST_IDLE) && (count_q == '0);
  assign overflow = overflow_q;

  // Pointer, occupancy and overflow bookkeeping; a write while full is dropped
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_fire);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(wr_fire) - CNT_W'(pop);
    overflow_d = send_en && send_busy;
  end

  // Frame sequencer: pops the FIFO head and walks start, data, parity, stop
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            if (count_q != '0) begin
              pop     = 1'b1;
              data_d  = mem_q[rd_ptr_q];
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
        bit_idx_d  = '0;
      end
    endcase
  end

  // Line level for the coming cycle, derived from the current state
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[bit_idx_q];
      ST_PARITY: tx_d = parity_bit;
      default:   tx_d = 1'b1;
    endcase
  end

  // State registers; reset idles the line and empties the queue immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are only meaningful while count covers them
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= send_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances with a 10-cycle bit period
// (no parity/depth 16, even parity 2 stop/depth 4, odd parity/depth 4).
module tb_uart_tx_fifo;

  localparam int BD = 10;

  logic       clk = 1'b0;
  logic       rstN;
  logic [2:0] sendEn;
  logic [7:0] sendData;
  logic [2:0] busyV, txV, idleV, ovfV;

  int nVec = 0;
  int nErr = 0;
  int cyc  = 0;
  int fallArr[17];

  always #5 clk = ~clk;

  // Free-running edge counter used to time frames
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLK_FRE(1), .UART_RATE(100000), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rstN), .send_en(sendEn[0]), .send_data(sendData),
    .send_busy(busyV[0]), .tx_pin(txV[0]), .tx_idle(idleV[0]), .overflow(ovfV[0]));

  uart_tx_fifo #(.CLK_FRE(1), .UART_RATE(100000), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rstN), .send_en(sendEn[1]), .send_data(sendData),
    .send_busy(busyV[1]), .tx_pin(txV[1]), .tx_idle(idleV[1]), .overflow(ovfV[1]));

  uart_tx_fifo #(.CLK_FRE(1), .UART_RATE(100000), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rstN), .send_en(sendEn[2]), .send_data(sendData),
    .send_busy(busyV[2]), .tx_pin(txV[2]), .tx_idle(idleV[2]), .overflow(ovfV[2]));

  // Advance one clock; all driving and sampling happens 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a byte with send_en high until an edge accepts it; send_en stays high
  task automatic applyStimulus(input int d, input logic [7:0] data, output logic accepted);
    logic b;
    int   waited;
    sendData  = data;
    sendEn[d] = 1'b1;
    waited    = 0;
    do begin
      b = busyV[d];
      tick();
      waited++;
    end while (b && waited < 400);
    accepted = !b;
  endtask

  // Receiver model: waits for a start edge, samples each bit mid-period
  task automatic rxByte(input int d, input logic [7:0] expByte, input int parMode,
                        input int stopBits, input string tag, output int fallCyc);
    int         waited;
    logic [7:0] got;
    logic       expPar;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (txV[d] !== 1'b0 && waited < 400);
    checkOutput({tag, " start edge seen"}, 32'(txV[d] === 1'b0), 32'd1);
    fallCyc = cyc;
    repeat (BD / 2) tick();
    checkOutput({tag, " start bit"}, 32'(txV[d]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) tick();
      got[i] = txV[d];
    end
    checkOutput({tag, " data"}, 32'(got), 32'(expByte));
    if (parMode != 0) begin
      expPar = (parMode == 1) ? ~^expByte : ^expByte;
      repeat (BD) tick();
      checkOutput({tag, " parity"}, 32'(txV[d]), 32'(expPar));
    end
    for (int s = 0; s < stopBits; s++) begin
      repeat (BD) tick();
      checkOutput({tag, " stop"}, 32'(txV[d]), 32'd1);
    end
  endtask

  initial begin
    string msg;
    logic  acc;
    int    wrCyc, fallA, fallB, lowCnt;

    msg      = "{plotter:00,00}\r\n";
    rstN     = 1'b0;
    sendEn   = 3'b000;
    sendData = 8'h00;

    // Reset state of all three instances
    repeat (3) tick();
    checkOutput("reset tx_pin",    32'(txV),   32'h7);
    checkOutput("reset send_busy", 32'(busyV), 32'h0);
    checkOutput("reset tx_idle",   32'(idleV), 32'h7);
    checkOutput("reset overflow",  32'(ovfV),  32'h0);
    rstN = 1'b1;
    repeat (2) tick();

    // Single byte 0x55: latency, bit pattern, tx_idle timing
    $display("[TB] single byte 0x55");
    applyStimulus(0, 8'h55, acc);
    sendEn[0] = 1'b0;
    wrCyc = cyc;
    checkOutput("t1 accepted", 32'(acc), 32'd1);
    checkOutput("t1 tx_idle after write", 32'(idleV[0]), 32'd0);
    checkOutput("t1 tx_pin edge N", 32'(txV[0]), 32'd1);
    tick();
    checkOutput("t1 tx_pin edge N+1", 32'(txV[0]), 32'd1);
    rxByte(0, 8'h55, 0, 1, "t1", fallA);
    checkOutput("t1 start latency", 32'(fallA - wrCyc), 32'd2);
    repeat (3) tick();
    checkOutput("t1 tx_idle in stop", 32'(idleV[0]), 32'd0);
    repeat (2) tick();
    checkOutput("t1 tx_idle after frame", 32'(idleV[0]), 32'd1);

    // 17-byte burst with send_en held, then one write while full
    $display("[TB] 17-byte burst and overflow");
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          applyStimulus(0, msg[i], acc);
          checkOutput("t2 accepted", 32'(acc), 32'd1);
          checkOutput("t2 overflow quiet", 32'(ovfV[0]), 32'd0);
        end
        checkOutput("t2 busy when full", 32'(busyV[0]), 32'd1);
        sendData = 8'hAA;
        tick();
        checkOutput("t3 overflow pulse", 32'(ovfV[0]), 32'd1);
        sendEn[0] = 1'b0;
        tick();
        checkOutput("t3 overflow single", 32'(ovfV[0]), 32'd0);
      end
      begin
        for (int i = 0; i < 17; i++) begin
          rxByte(0, msg[i], 0, 1, "t2 rx", fallArr[i]);
          if (i > 0) checkOutput("t2 frame spacing", 32'(fallArr[i] - fallArr[i-1]), 32'd100);
        end
      end
    join
    checkOutput("t2 total span", 32'(fallArr[16] - fallArr[0] + 100), 32'd1700);
    repeat (10) tick();
    checkOutput("t3 idle after burst", 32'(idleV[0]), 32'd1);
    lowCnt = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (txV[0] !== 1'b1) lowCnt++;
    end
    checkOutput("t3 0xAA never sent", 32'(lowCnt), 32'd0);

    // Parity and stop-bit variants with 0x07 followed by 0x31
    $display("[TB] parity variants");
    applyStimulus(1, 8'h07, acc);
    applyStimulus(1, 8'h31, acc);
    sendEn[1] = 1'b0;
    rxByte(1, 8'h07, 2, 2, "t4 even", fallA);
    rxByte(1, 8'h31, 2, 2, "t4 even", fallB);
    checkOutput("t4 even frame length", 32'(fallB - fallA), 32'd120);
    applyStimulus(2, 8'h07, acc);
    applyStimulus(2, 8'h31, acc);
    sendEn[2] = 1'b0;
    rxByte(2, 8'h07, 1, 1, "t4 odd", fallA);
    rxByte(2, 8'h31, 1, 1, "t4 odd", fallB);
    checkOutput("t4 odd frame length", 32'(fallB - fallA), 32'd110);

    // Reset during the third queued frame, then a clean byte
    $display("[TB] reset mid-frame");
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h41 + 8'(i), acc);
    sendEn[0] = 1'b0;
    repeat (247) tick();
    checkOutput("t5 tx low before reset", 32'(txV[0]), 32'd0);
    rstN = 1'b0;
    #1;
    checkOutput("t5 tx high in reset", 32'(txV[0]), 32'd1);
    checkOutput("t5 idle in reset", 32'(idleV[0]), 32'd1);
    checkOutput("t5 busy in reset", 32'(busyV[0]), 32'd0);
    repeat (2) tick();
    rstN = 1'b1;
    tick();
    checkOutput("t5 idle after release", 32'(idleV[0]), 32'd1);
    applyStimulus(0, 8'h31, acc);
    sendEn[0] = 1'b0;
    rxByte(0, 8'h31, 0, 1, "t5 rx", fallA);
    lowCnt = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (txV[0] !== 1'b1) lowCnt++;
    end
    checkOutput("t5 no remnant frames", 32'(lowCnt), 32'd0);
    checkOutput("t5 idle at end", 32'(idleV[0]), 32'd1);

    // Depth-4 FIFO streamed through several pointer wraps
    $display("[TB] depth 4 wraps");
    fork
      begin
        for (int i = 0; i < 14; i++) begin
          applyStimulus(2, 8'hC0 + 8'(i), acc);
          checkOutput("t6 accepted", 32'(acc), 32'd1);
          checkOutput("t6 busy after accept", 32'(busyV[2]), 32'(i >= 4));
        end
        sendEn[2] = 1'b0;
      end
      begin
        for (int i = 0; i < 14; i++) begin
          rxByte(2, 8'hC0 + 8'(i), 1, 1, "t6 rx", fallArr[i]);
        end
      end
    join
    repeat (10) tick();
    checkOutput("t6 idle at end", 32'(idleV[2]), 32'd1);
    checkOutput("t6 busy at end", 32'(busyV[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
